sprite_blitter: RTL and testbench

- Copies a rectangular sprite from a palette-decoded sprite RAM into FramebufferRam, one pixel per clock.
- Skips transparent (key-colour) pixels and pixels that fall off screen. Optionally mirrors the sprite horizontally.
- Sits between the game-logic/draw scheduler and the framebuffer write port. It drives the framebuffer's write_address/data_In/we side and the sprite RAM's read side.

---
 rtl/sprite_blitter.sv | 152 +++++++++++++++
 tb/tb_sprite_blitter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite copy into the framebuffer with colour-key transparency, screen clipping and optional h-mirror.
// Latency: done N+2 cycles after the accepted start; no backpressure, start is ignored unless idle.
module sprite_blitter #(
    parameter int          FB_W      = 240,
    parameter int          FB_H      = 160,
    parameter int          SRC_W     = 112,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [8:0]  src_x,
    input  logic [8:0]  src_y,
    input  logic [6:0]  width,
    input  logic [6:0]  height,
    input  logic [8:0]  dst_x,
    input  logic [8:0]  dst_y,
    input  logic        flip_h,
    output logic        busy,
    output logic        done,
    output logic [18:0] src_read_address,
    input  logic [23:0] src_data,
    output logic [18:0] fb_write_address,
    output logic [23:0] fb_data_In,
    output logic        fb_we
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [6:0]  w_q, w_n, h_q, h_n, col_q, col_n, row_q, row_n;
    logic [8:0]  dx_q, dx_n, dy_q, dy_n;
    logic        flip_q, flip_n;
    logic [18:0] sbase_q, sbase_n, dbase_q, dbase_n;
    logic        drain_q, drain_n;
    logic        busy_n, done_n, issue;
    logic [6:0]  scol;
    logic [9:0]  xsum, ysum;
    logic [18:0] saddr_n, p0_addr_n;
    logic        p0_inb_n;
    logic        p0_vld, p0_inb, p1_vld, p1_inb;
    logic [18:0] p0_addr, p1_addr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        w_n       = w_q;
        h_n       = h_q;
        dx_n      = dx_q;
        dy_n      = dy_q;
        flip_n    = flip_q;
        col_n     = col_q;
        row_n     = row_q;
        sbase_n   = sbase_q;
        dbase_n   = dbase_q;
        drain_n   = drain_q;
        busy_n    = busy;
        done_n    = 1'b0;
        issue     = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                w_n    = width;
                h_n    = height;
                dx_n   = dst_x;
                dy_n   = dst_y;
                flip_n = flip_h;
                col_n  = '0;
                row_n  = '0;
                // Constant-coefficient products for the first row; later rows accumulate.
                sbase_n = 19'(src_y) * 19'(SRC_W) + 19'(src_x);
                dbase_n = 19'(dst_y) * 19'(FB_W) + 19'(dst_x);
                if (width == 7'd0 || height == 7'd0) begin
                    state_nxt = S_DONE;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                end else begin
                    state_nxt = S_RUN;
                    busy_n    = 1'b1;
                    issue     = 1'b1;
                end
            end
            S_RUN: begin
                if (col_q == w_q - 7'd1) begin
                    if (row_q == h_q - 7'd1) begin
                        state_nxt = S_DRAIN;
                        drain_n   = 1'b0;
                    end else begin
                        col_n   = '0;
                        row_n   = row_q + 7'd1;
                        sbase_n = sbase_q + 19'(SRC_W);
                        dbase_n = dbase_q + 19'(FB_W);
                        issue   = 1'b1;
                    end
                end else begin
                    col_n = col_q + 7'd1;
                    issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_nxt = S_DONE;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                end else begin
                    drain_n = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        scol      = flip_n ? (w_n - 7'd1 - col_n) : col_n;
        saddr_n   = sbase_n + 19'(scol);
        p0_addr_n = dbase_n + 19'(col_n);
        xsum      = 10'(dx_n) + 10'(col_n);
        ysum      = 10'(dy_n) + 10'(row_n);
        p0_inb_n  = (xsum < 10'(FB_W)) && (ysum < 10'(FB_H));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            w_q <= '0; h_q <= '0; dx_q <= '0; dy_q <= '0; flip_q <= 1'b0;
            col_q <= '0; row_q <= '0; sbase_q <= '0; dbase_q <= '0; drain_q <= 1'b0;
            busy <= 1'b0; done <= 1'b0; src_read_address <= '0;
            p0_vld <= 1'b0; p0_inb <= 1'b0; p0_addr <= '0;
            p1_vld <= 1'b0; p1_inb <= 1'b0; p1_addr <= '0;
            fb_we <= 1'b0; fb_write_address <= '0; fb_data_In <= '0;
        end else begin
            w_q <= w_n; h_q <= h_n; dx_q <= dx_n; dy_q <= dy_n; flip_q <= flip_n;
            col_q <= col_n; row_q <= row_n; sbase_q <= sbase_n; dbase_q <= dbase_n;
            drain_q <= drain_n;
            busy    <= busy_n;
            done    <= done_n;
            if (issue) src_read_address <= saddr_n;
            // Destination info rides two stages to line up with the RAM's read latency.
            p0_vld  <= issue;
            p0_inb  <= p0_inb_n;
            p0_addr <= p0_addr_n;
            p1_vld  <= p0_vld;
            p1_inb  <= p0_inb;
            p1_addr <= p0_addr;
            fb_we            <= p1_vld && p1_inb && (src_data != KEY_COLOR);
            fb_write_address <= p1_addr;
            fb_data_In       <= src_data;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized scoreboard bench for sprite_blitter with a behavioural sprite RAM.
module tb_sprite_blitter;
    localparam int          FB_W  = 240;
    localparam int          FB_H  = 160;
    localparam int          SRC_W = 112;
    localparam logic [23:0] KEY   = 24'hFF00FF;

    logic        Clk = 1'b0, Reset_n = 1'b0, start = 1'b0;
    logic [8:0]  src_x = '0, src_y = '0, dst_x = '0, dst_y = '0;
    logic [6:0]  width = '0, height = '0;
    logic        flip_h = 1'b0;
    logic        busy, done, fb_we;
    logic [18:0] src_read_address, fb_write_address;
    logic [23:0] src_data = '0, fb_data_In;

    int checks = 0, errors = 0, cyc = 0, key_a = -1, wr_count = 0;

    typedef struct {int cyc; int addr; int data;} ev_t;
    ev_t rd_q[$], wr_q[$];
    int  done_q[$];
    ev_t me;

    sprite_blitter dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .src_x(src_x), .src_y(src_y), .width(width), .height(height),
        .dst_x(dst_x), .dst_y(dst_y), .flip_h(flip_h),
        .busy(busy), .done(done),
        .src_read_address(src_read_address), .src_data(src_data),
        .fb_write_address(fb_write_address), .fb_data_In(fb_data_In), .fb_we(fb_we)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] pix(input int a);
        logic [23:0] h;
        if (a == key_a || a % 7 == 3) return KEY;
        h = 24'(a * 40503 + 4660);
        if (h == KEY) h = h ^ 24'h1;
        return h;
    endfunction

    // Sprite RAM: one cycle read latency.
    always @(posedge Clk) begin
        cyc      <= cyc + 1;
        src_data <= pix(int'(src_read_address));
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Monitor: consumes expected events cycle by cycle.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                me = rd_q.pop_front();
                checks++;
                if (src_read_address !== 19'(me.addr)) begin
                    errors++;
                    $display("FAIL rd_addr cyc %0d got %0d want %0d", cyc, src_read_address, me.addr);
                end
            end
            if (fb_we) begin
                wr_count++;
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc %0d addr %0d want no write", cyc, fb_write_address);
                end else begin
                    me = wr_q.pop_front();
                    if (me.cyc != cyc || fb_write_address !== 19'(me.addr) || fb_data_In !== 24'(me.data)) begin
                        errors++;
                        $display("FAIL write got cyc %0d addr %0d data %06h want cyc %0d addr %0d data %06h",
                                 cyc, fb_write_address, fb_data_In, me.cyc, me.addr, me.data);
                    end
                end
            end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
                me = wr_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_write cyc %0d got none want addr %0d", cyc, me.addr);
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc %0d got done want none", cyc);
                end else if (done_q[0] != cyc || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing got cyc %0d busy %0b want cyc %0d busy 0", cyc, busy, done_q[0]);
                    void'(done_q.pop_front());
                end else begin
                    void'(done_q.pop_front());
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                checks++; errors++;
                $display("FAIL missing_done cyc %0d got none want cyc %0d", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
        end
    end

    // Reference model: enumerate pixels row by row and derive reads, writes and done cycle.
    task automatic expect_blit(input int c0, input int sx, input int sy, input int w, input int h,
                               input int dx, input int dy, input bit fl);
        int k;
        int sa, px, py;
        logic [23:0] d;
        ev_t e;
        k = 0;
        if (w == 0 || h == 0) begin
            done_q.push_back(c0);
            return;
        end
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                sa = ((sy + r) * SRC_W + sx + (fl ? (w - 1 - c) : c)) & 'h7FFFF;
                px = dx + c;
                py = dy + r;
                d  = pix(sa);
                e.cyc = c0 + k; e.addr = sa; e.data = 0;
                rd_q.push_back(e);
                if (d != KEY && px < FB_W && py < FB_H) begin
                    e.cyc = c0 + k + 2; e.addr = (py * FB_W + px) & 'h7FFFF; e.data = int'(d);
                    wr_q.push_back(e);
                end
                k++;
            end
        end
        done_q.push_back(c0 + w * h + 2);
    endtask

    task automatic set_params(input int sx, input int sy, input int w, input int h,
                              input int dx, input int dy, input bit fl);
        src_x = 9'(sx); src_y = 9'(sy); width = 7'(w); height = 7'(h);
        dst_x = 9'(dx); dst_y = 9'(dy); flip_h = fl;
    endtask

    task automatic blit(input int sx, input int sy, input int w, input int h,
                        input int dx, input int dy, input bit fl);
        int c0;
        set_params(sx, sy, w, h, dx, dy, fl);
        start = 1'b1;
        @(posedge Clk); #1;
        c0 = cyc;
        start = 1'b0;
        expect_blit(c0, sx, sy, w, h, dx, dy, fl);
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!done && n < lim) begin
            @(posedge Clk); #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout got no done want done within %0d cycles", lim);
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        int w0, c0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_src_addr", src_read_address, 0);
        chk("rst_fb_addr", fb_write_address, 0);
        chk("rst_fb_data", fb_data_In, 0);
        @(negedge Clk) Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        w0 = wr_count;
        blit(0, 0, 2, 2, 10, 5, 0);
        wait_done(20);
        chk("writes_2x2", wr_count - w0, 4);

        key_a = 1;
        w0 = wr_count;
        blit(0, 0, 2, 2, 10, 5, 0);
        wait_done(20);
        chk("writes_key", wr_count - w0, 3);
        key_a = -1;

        blit(4, 0, 3, 1, 20, 30, 1);
        wait_done(20);

        w0 = wr_count;
        blit(0, 0, 4, 4, 238, 158, 0);
        wait_done(40);
        chk("writes_clip", wr_count - w0, 4);

        w0 = wr_count;
        blit(5, 5, 0, 5, 0, 0, 0);
        wait_done(5);
        blit(5, 5, 6, 0, 0, 0, 0);
        wait_done(5);
        chk("writes_empty", wr_count - w0, 0);

        // start during a blit must be ignored
        blit(7, 9, 3, 3, 50, 60, 0);
        repeat (2) @(posedge Clk);
        #1;
        set_params(1, 1, 5, 5, 0, 0, 1);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done(30);

        // start held high: second blit accepted the cycle after done
        set_params(30, 2, 2, 1, 100, 100, 0);
        start = 1'b1;
        @(posedge Clk); #1;
        c0 = cyc;
        expect_blit(c0, 30, 2, 2, 1, 100, 100, 0);
        expect_blit(c0 + 6, 30, 2, 2, 1, 100, 100, 0);
        repeat (6) @(posedge Clk);
        #1;
        start = 1'b0;
        wait_done(20);

        // reset in the middle of an 8x8 blit
        blit(10, 20, 8, 8, 100, 50, 0);
        repeat (20) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midrst_fb_we", fb_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rd_q.delete(); wr_q.delete(); done_q.delete();
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk); #1;
        w0 = wr_count;
        blit(10, 20, 8, 8, 100, 50, 0);
        wait_done(100);
        chk("writes_after_rst_min", (wr_count - w0) > 40, 1);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            #1;
            blit($urandom_range(0, 511), $urandom_range(0, 511),
                 $urandom_range(0, 10), $urandom_range(0, 10),
                 $urandom_range(0, 250), $urandom_range(0, 170), 1'($urandom_range(0, 1)));
            wait_done(150);
        end

        repeat (4) @(posedge Clk);
        #1;
        chk("leftover_expected", rd_q.size() + wr_q.size() + done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
